// File: rtl/pi1_rrarb_if.sv
// Bus bundle between MASTERCOUNT pi1 masters, the round-robin arbiter and one pi1 slave.
// The master modport is the arbiter's view; the slave modport is the surrounding fabric.
interface pi1_rrarb_if #(
    parameter int unsigned MASTERCOUNT = 2,
    parameter int unsigned ARCHBITSZ   = 32
);
    localparam int unsigned SELBITSZ  = ARCHBITSZ / 8;
    localparam int unsigned ADDRBITSZ = ARCHBITSZ - $clog2(SELBITSZ);

    logic [2*MASTERCOUNT-1:0]         m_op_i;
    logic [ADDRBITSZ*MASTERCOUNT-1:0] m_addr_i;
    logic [ARCHBITSZ*MASTERCOUNT-1:0] m_data_i;
    logic [SELBITSZ*MASTERCOUNT-1:0]  m_sel_i;
    logic [ARCHBITSZ-1:0]             m_data_o;
    logic [MASTERCOUNT-1:0]           m_rdy_o;
    logic [1:0]                       s_op_o;
    logic [ADDRBITSZ-1:0]             s_addr_o;
    logic [ARCHBITSZ-1:0]             s_data_o;
    logic [SELBITSZ-1:0]              s_sel_o;
    logic [ARCHBITSZ-1:0]             s_data_i;
    logic                             s_rdy_i;

    modport master (
        input  m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i, s_rdy_i,
        output m_data_o, m_rdy_o, s_op_o, s_addr_o, s_data_o, s_sel_o
    );

    modport slave (
        output m_op_i, m_addr_i, m_data_i, m_sel_i, s_data_i, s_rdy_i,
        input  m_data_o, m_rdy_o, s_op_o, s_addr_o, s_data_o, s_sel_o
    );
endinterface

// File: rtl/pi1_rrarb.sv
// Round-robin arbiter sharing one pi1 slave port among MASTERCOUNT masters.
// Payloads are not latched: the granted master's inputs are muxed straight through in XFER.
module pi1_rrarb #(
    parameter  int unsigned MASTERCOUNT = 2,
    parameter  int unsigned ARCHBITSZ   = 32,
    localparam int unsigned GNTBITSZ    = $clog2(MASTERCOUNT)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    pi1_rrarb_if.master         bus,
    output logic [GNTBITSZ-1:0] gnt_o,
    output logic                busy_o
);
    localparam int unsigned SELBITSZ  = ARCHBITSZ / 8;
    localparam int unsigned ADDRBITSZ = ARCHBITSZ - $clog2(SELBITSZ);
    localparam logic [1:0]  OP_NOOP   = 2'd0;
    localparam logic [1:0]  OP_WR     = 2'd1;

    typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

    state_t                 r_state, w_state_nxt;
    logic [GNTBITSZ-1:0]    r_gnt, w_gnt_nxt;
    logic [GNTBITSZ-1:0]    r_last, w_last_nxt;
    logic [GNTBITSZ-1:0]    w_rr_gnt;
    logic                   w_rr_found;
    logic [1:0]             w_op;
    logic [ADDRBITSZ-1:0]   w_addr;
    logic [ARCHBITSZ-1:0]   w_data;
    logic [SELBITSZ-1:0]    w_sel;
    logic [MASTERCOUNT-1:0] w_rdy;

    always_comb begin
        w_op   = '0;
        w_addr = '0;
        w_data = '0;
        w_sel  = '0;
        for (int unsigned i = 0; i < MASTERCOUNT; i++) begin
            if (r_gnt == GNTBITSZ'(i)) begin
                w_op   = bus.m_op_i[2*i +: 2];
                w_addr = bus.m_addr_i[ADDRBITSZ*i +: ADDRBITSZ];
                w_data = bus.m_data_i[ARCHBITSZ*i +: ARCHBITSZ];
                w_sel  = bus.m_sel_i[SELBITSZ*i +: SELBITSZ];
            end
        end
    end

    // Search starts one past the last completed grant and wraps, so the first hit is the fairest.
    always_comb begin
        int unsigned idx;
        idx        = 0;
        w_rr_gnt   = r_gnt;
        w_rr_found = 1'b0;
        for (int unsigned k = 1; k <= MASTERCOUNT; k++) begin
            idx = (32'(r_last) + k) % MASTERCOUNT;
            if (!w_rr_found && bus.m_op_i[2*idx +: 2] != OP_NOOP) begin
                w_rr_found = 1'b1;
                w_rr_gnt   = GNTBITSZ'(idx);
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_last_nxt   = r_last;
        w_rdy        = '0;
        bus.s_op_o   = '0;
        bus.s_addr_o = '0;
        bus.s_data_o = '0;
        bus.s_sel_o  = '0;
        case (r_state)
            IDLE: begin
                if (w_rr_found) begin
                    w_gnt_nxt   = w_rr_gnt;
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                bus.s_op_o   = w_op;
                bus.s_addr_o = w_addr;
                bus.s_data_o = w_data;
                bus.s_sel_o  = w_sel;
                if (w_op == OP_NOOP) begin
                    w_state_nxt = IDLE;
                end else if (bus.s_rdy_i) begin
                    if (w_op == OP_WR) begin
                        w_rdy       = MASTERCOUNT'(1) << r_gnt;
                        w_last_nxt  = r_gnt;
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt = RESP;
                    end
                end
            end
            RESP: begin
                if (bus.s_rdy_i) begin
                    w_rdy       = MASTERCOUNT'(1) << r_gnt;
                    w_last_nxt  = r_gnt;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Reset abandons an in-flight transfer, so the completion strobe is suppressed in that cycle.
    assign bus.m_rdy_o  = rst_i ? '0 : w_rdy;
    assign bus.m_data_o = bus.s_data_i;
    assign gnt_o        = r_gnt;
    assign busy_o       = (r_state != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_last  <= GNTBITSZ'(MASTERCOUNT - 1);
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
        end
    end
endmodule

// File: tb/tb_pi1_rrarb.sv
// Directed bench for pi1_rrarb with four masters; completions are checked by a scoreboard monitor.
module tb_pi1_rrarb;
    localparam int unsigned MC = 4;
    localparam logic [1:0]  NOOP = 2'd0;
    localparam logic [1:0]  WR   = 2'd1;
    localparam logic [1:0]  RD   = 2'd2;

    typedef struct {
        int unsigned m;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [1:0]  gnt;
    logic        busy;
    int          errors;
    int          checks;
    exp_t        sb[$];

    pi1_rrarb_if #(.MASTERCOUNT(MC), .ARCHBITSZ(32)) bus ();

    pi1_rrarb #(.MASTERCOUNT(MC), .ARCHBITSZ(32)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus),
        .gnt_o  (gnt),
        .busy_o (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int unsigned m, input logic [1:0] op);
        bus.m_op_i[2*m +: 2]    = op;
        bus.m_addr_i[30*m +: 30] = 30'(32'h100 + m);
        bus.m_data_i[32*m +: 32] = 32'hA000_0000 + m;
        bus.m_sel_i[4*m +: 4]    = 4'hF;
    endtask

    task automatic push(input int unsigned m, input logic rd, input logic [31:0] data);
        exp_t e;
        e.m = m;
        e.rd = rd;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One write transaction: an IDLE cycle followed by the XFER cycle that completes.
    task automatic round(input int unsigned exp_gnt);
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_sop", 32'(bus.s_op_o), 32'd0);
        cyc();
        @(negedge clk);
        chk("rr_gnt", 32'(gnt), exp_gnt);
        chk("rr_saddr", 32'(bus.s_addr_o), 32'h100 + exp_gnt);
        cyc();
    endtask

    always @(negedge clk) begin
        if (bus.m_rdy_o != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rdy: got m_rdy_o=%b expected none at %0t", bus.m_rdy_o, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_rdy", 32'(bus.m_rdy_o), 32'd1 << e.m);
                if (e.rd) chk("sb_rdata", bus.m_data_o, e.data);
            end
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.m_op_i   = '0;
        bus.m_addr_i = '0;
        bus.m_data_i = '0;
        bus.m_sel_i  = '0;
        bus.s_data_i = '0;
        bus.s_rdy_i  = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_sop", 32'(bus.s_op_o), 32'd0);
        chk("rst_rdy", 32'(bus.m_rdy_o), 32'd0);
        chk("rst_gnt", 32'(gnt), 32'd0);
        cyc();
        rst = 1'b0;

        // master0 write, slave always ready
        set_req(0, WR);
        bus.s_rdy_i = 1'b1;
        push(0, 1'b0, 32'd0);
        @(negedge clk);
        chk("wr_c0_busy", 32'(busy), 32'd0);
        cyc();
        @(negedge clk);
        chk("wr_c1_gnt", 32'(gnt), 32'd0);
        chk("wr_c1_busy", 32'(busy), 32'd1);
        chk("wr_c1_sop", 32'(bus.s_op_o), 32'd1);
        chk("wr_c1_sdata", bus.s_data_o, 32'hA000_0000);
        chk("wr_c1_ssel", 32'(bus.s_sel_o), 32'hF);
        chk("wr_c1_rdy", 32'(bus.m_rdy_o), 32'b0001);
        cyc();
        set_req(0, NOOP);
        @(negedge clk);
        chk("wr_c2_busy", 32'(busy), 32'd0);

        // master1 read with a stalled response phase
        cyc();
        set_req(1, RD);
        @(negedge clk);
        chk("rd_idle_busy", 32'(busy), 32'd0);
        cyc();
        @(negedge clk);
        chk("rd_xfer_gnt", 32'(gnt), 32'd1);
        chk("rd_xfer_sop", 32'(bus.s_op_o), 32'd2);
        chk("rd_xfer_rdy", 32'(bus.m_rdy_o), 32'd0);
        cyc();
        bus.s_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rd_resp_sop", 32'(bus.s_op_o), 32'd0);
            chk("rd_resp_busy", 32'(busy), 32'd1);
            cyc();
        end
        bus.s_data_i = 32'hDEADBEEF;
        bus.s_rdy_i  = 1'b1;
        push(1, 1'b1, 32'hDEADBEEF);
        @(negedge clk);
        chk("rd_done_rdy", 32'(bus.m_rdy_o), 32'b0010);
        cyc();
        set_req(1, NOOP);
        bus.s_rdy_i  = 1'b0;
        bus.s_data_i = '0;
        @(negedge clk);
        chk("rd_after_rdy", 32'(bus.m_rdy_o), 32'd0);
        chk("rd_after_busy", 32'(busy), 32'd0);

        // all four masters writing continuously from a fresh reset
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.s_rdy_i = 1'b1;
        for (int unsigned m = 0; m < MC; m++) set_req(m, WR);
        push(0, 1'b0, 0); push(1, 1'b0, 0); push(2, 1'b0, 0); push(3, 1'b0, 0); push(0, 1'b0, 0);
        round(0); round(1); round(2); round(3); round(0);
        for (int unsigned m = 0; m < MC; m++) set_req(m, NOOP);

        // wrap-around: last=2 with masters 0 and 2 requesting
        set_req(2, WR);
        push(2, 1'b0, 0);
        round(2);
        set_req(0, WR);
        push(0, 1'b0, 0); push(2, 1'b0, 0);
        round(0); round(2);
        set_req(0, NOOP);
        set_req(2, NOOP);

        // reset during RESP abandons the read
        set_req(3, RD);
        @(negedge clk);
        chk("rr_busy", 32'(busy), 32'd0);
        cyc();
        @(negedge clk);
        chk("rr_gnt3", 32'(gnt), 32'd3);
        cyc();
        bus.s_rdy_i = 1'b0;
        @(negedge clk);
        chk("rr_resp_busy", 32'(busy), 32'd1);
        cyc();
        rst = 1'b1;
        bus.s_rdy_i = 1'b1;
        @(negedge clk);
        chk("rr_rst_rdy", 32'(bus.m_rdy_o), 32'd0);
        cyc();
        rst = 1'b0;
        set_req(0, WR);
        push(0, 1'b0, 0);
        round(0);
        set_req(0, NOOP);
        set_req(3, NOOP);

        // granted master withdraws its request in XFER
        bus.s_rdy_i = 1'b0;
        set_req(1, WR);
        @(negedge clk);
        chk("wd_idle_busy", 32'(busy), 32'd0);
        cyc();
        set_req(1, NOOP);
        @(negedge clk);
        chk("wd_gnt", 32'(gnt), 32'd1);
        chk("wd_sop", 32'(bus.s_op_o), 32'd0);
        chk("wd_rdy", 32'(bus.m_rdy_o), 32'd0);
        cyc();
        @(negedge clk);
        chk("wd_back_idle", 32'(busy), 32'd0);
        cyc();
        bus.s_rdy_i = 1'b1;
        set_req(1, WR);
        set_req(3, WR);
        push(1, 1'b0, 0);
        round(1);
        set_req(1, NOOP);
        set_req(3, NOOP);

        repeat (3) cyc();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
